// File: rtl/bitonic_sort_sequencer.sv
// Gathers serial elements into SIZE-wide blocks, launches them into an external
// fixed-latency bitonic sorter when buffer space is guaranteed, captures the
// sorted blocks and drains them serially with valid/ready handshaking.
// Optional performance counters are enabled by defining BITONIC_SEQ_PERF_EN.
module bitonic_sort_sequencer #(
    parameter int VALUE_BITS = 8,
    parameter int DEPTH      = 3,
    parameter int DIRECTION  = 0,
    parameter int LATENCY    = 6,
    parameter int BUF_BLOCKS = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [VALUE_BITS-1:0]               in_data,
    input  logic                                in_last,
    output logic [(1<<DEPTH)*VALUE_BITS-1:0]    sort_in,
    input  logic [(1<<DEPTH)*VALUE_BITS-1:0]    sort_out,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [VALUE_BITS-1:0]               out_data,
    output logic                                out_last,
    output logic                                busy
`ifdef BITONIC_SEQ_PERF_EN
    ,
    output logic [31:0]                         perf_blocks,
    output logic [31:0]                         perf_stall,
    output logic [31:0]                         perf_partial
`endif
);

    localparam int SIZE = 1 << DEPTH;
    localparam int BW   = SIZE * VALUE_BITS;
    localparam int CW   = DEPTH + 1;
    localparam int PW   = (BUF_BLOCKS > 1) ? $clog2(BUF_BLOCKS) : 1;
    localparam int OW   = $clog2(BUF_BLOCKS + 1);
    // Pads sort to the top indices so real elements always occupy 0..n-1
    localparam logic [VALUE_BITS-1:0] PAD = (DIRECTION == 0) ? {VALUE_BITS{1'b1}} : {VALUE_BITS{1'b0}};
    localparam logic [BW-1:0] PAD_BLOCK = {SIZE{PAD}};

    typedef enum logic {FILL, LAUNCH_WAIT} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [BW-1:0]   gath_reg;
    logic            in_ready_reg;
    logic [BW-1:0]   sort_in_reg;
    logic            launch_vld_reg;
    logic [CW-1:0]   launch_n_reg;
    logic            pipe_vld_reg [LATENCY];
    logic [CW-1:0]   pipe_n_reg   [LATENCY];
    logic [OW-1:0]   inflight_reg;
    logic [OW-1:0]   buffered_reg;
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [DEPTH-1:0] idx_reg;
    logic [BW-1:0]   buf_data_mem [BUF_BLOCKS];
    logic [CW-1:0]   buf_n_mem    [BUF_BLOCKS];

    logic [BW-1:0]   merged;
    logic [BW-1:0]   launch_block;
    logic [CW-1:0]   launch_n;
    logic [BW-1:0]   head_word;
    logic            accept, close_now, credit, launch, capture, handshake, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_BLOCKS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Gather block with the incoming element dropped into slot cnt
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_merge
            assign merged[gi*VALUE_BITS +: VALUE_BITS] =
                (cnt_reg == CW'(gi)) ? in_data : gath_reg[gi*VALUE_BITS +: VALUE_BITS];
        end
    endgenerate

    // Close/credit/launch decisions; credit counts a pop happening this cycle
    always_comb begin
        accept       = in_ready && in_valid;
        close_now    = accept && ((cnt_reg == CW'(SIZE - 1)) || in_last);
        credit       = (int'(inflight_reg) + int'(buffered_reg) - int'(pop)) < BUF_BLOCKS;
        launch       = (state_reg == FILL) ? (close_now && credit) : credit;
        launch_block = (state_reg == FILL) ? merged : gath_reg;
        launch_n     = (state_reg == FILL) ? cnt_reg + 1'b1 : cnt_reg;
        capture      = pipe_vld_reg[LATENCY-1];
    end

    // Gather FSM: FILL accepts elements, LAUNCH_WAIT holds a closed block until credit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= FILL;
            cnt_reg      <= '0;
            gath_reg     <= PAD_BLOCK;
            in_ready_reg <= 1'b0;
        end else begin
            in_ready_reg <= 1'b1;
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        if (close_now && credit) begin
                            gath_reg <= PAD_BLOCK;
                            cnt_reg  <= '0;
                        end else begin
                            gath_reg <= merged;
                            cnt_reg  <= cnt_reg + 1'b1;
                            if (close_now) begin
                                state_reg    <= LAUNCH_WAIT;
                                in_ready_reg <= 1'b0;
                            end
                        end
                    end
                end
                LAUNCH_WAIT: begin
                    if (credit) begin
                        gath_reg  <= PAD_BLOCK;
                        cnt_reg   <= '0;
                        state_reg <= FILL;
                    end else begin
                        in_ready_reg <= 1'b0;
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    // Launch register and in-flight tracker; sort_out matches sort_in LATENCY cycles later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sort_in_reg    <= PAD_BLOCK;
            launch_vld_reg <= 1'b0;
            launch_n_reg   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld_reg[i] <= 1'b0;
                pipe_n_reg[i]   <= '0;
            end
        end else begin
            launch_vld_reg <= launch;
            if (launch) begin
                sort_in_reg  <= launch_block;
                launch_n_reg <= launch_n;
            end
            pipe_vld_reg[0] <= launch_vld_reg;
            pipe_n_reg[0]   <= launch_n_reg;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_reg[i] <= pipe_vld_reg[i-1];
                pipe_n_reg[i]   <= pipe_n_reg[i-1];
            end
        end
    end

    // Block buffer storage; contents are qualified by the occupancy counters
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_data_mem[tail_reg] <= sort_out;
            buf_n_mem[tail_reg]    <= pipe_n_reg[LATENCY-1];
        end
    end

    // Occupancy counters, buffer pointers and drain index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_reg <= '0;
            buffered_reg <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            idx_reg      <= '0;
        end else begin
            inflight_reg <= inflight_reg + OW'(launch) - OW'(capture);
            buffered_reg <= buffered_reg + OW'(capture) - OW'(pop);
            if (capture) tail_reg <= ptr_inc(tail_reg);
            if (handshake) begin
                if (out_last) begin
                    idx_reg  <= '0;
                    head_reg <= ptr_inc(head_reg);
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    assign head_word = buf_data_mem[head_reg];
    assign out_valid = (buffered_reg != '0);
    assign out_data  = out_valid ? head_word[idx_reg*VALUE_BITS +: VALUE_BITS] : '0;
    assign out_last  = out_valid && (CW'(idx_reg) == buf_n_mem[head_reg] - 1'b1);
    assign handshake = out_valid && out_ready;
    assign pop       = handshake && out_last;
    assign in_ready  = in_ready_reg && rst_n;
    assign sort_in   = sort_in_reg;
    assign busy      = (cnt_reg != '0) || (state_reg == LAUNCH_WAIT) ||
                       (inflight_reg != '0) || (buffered_reg != '0);

`ifdef BITONIC_SEQ_PERF_EN
    logic [31:0] perf_blocks_reg, perf_stall_reg, perf_partial_reg;

    // Free-running event counters, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_blocks_reg  <= '0;
            perf_stall_reg   <= '0;
            perf_partial_reg <= '0;
        end else begin
            if (launch) perf_blocks_reg <= perf_blocks_reg + 1'b1;
            if (state_reg == LAUNCH_WAIT && in_valid) perf_stall_reg <= perf_stall_reg + 1'b1;
            if (launch && launch_n != CW'(SIZE)) perf_partial_reg <= perf_partial_reg + 1'b1;
        end
    end

    assign perf_blocks  = perf_blocks_reg;
    assign perf_stall   = perf_stall_reg;
    assign perf_partial = perf_partial_reg;
`endif

endmodule

// File: tb/tb_bitonic_sort_sequencer.sv
// Self-checking bench: dut0 ascending with two buffer blocks, dut1 descending
// with one buffer block. Each DUT drives a behavioural sorter pipeline; a
// monitor keeps a per-block software-sort reference and scores every output.
module tb_bitonic_sort_sequencer;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid [2];
    logic        in_ready [2];
    logic        in_last  [2];
    logic [7:0]  in_data  [2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic        out_last [2];
    logic [7:0]  out_data [2];
    logic        busy     [2];
    logic [63:0] sort_in_w[2];
    logic [63:0] spipe    [2][LAT];

    int checks = 0;
    int errors = 0;

    logic [7:0] cur_blk [2][$];
    logic [8:0] exp_q   [2][$];
    logic       prev_stall[2];
    logic [7:0] prev_data [2];
    int         mon_n;
    logic [7:0] mon_a [8];
    logic [7:0] mon_t;

`ifdef BITONIC_SEQ_PERF_EN
    logic [31:0] pb[2], ps[2], pp[2];
`endif

    always #5 clk = ~clk;

    bitonic_sort_sequencer #(.DIRECTION(0), .BUF_BLOCKS(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
        .sort_in(sort_in_w[0]), .sort_out(spipe[0][LAT-1]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .busy(busy[0])
`ifdef BITONIC_SEQ_PERF_EN
        , .perf_blocks(pb[0]), .perf_stall(ps[0]), .perf_partial(pp[0])
`endif
    );

    bitonic_sort_sequencer #(.DIRECTION(1), .BUF_BLOCKS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
        .sort_in(sort_in_w[1]), .sort_out(spipe[1][LAT-1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .busy(busy[1])
`ifdef BITONIC_SEQ_PERF_EN
        , .perf_blocks(pb[1]), .perf_stall(ps[1]), .perf_partial(pp[1])
`endif
    );

    // Behavioural full-block sorter used as the external sorter
    function automatic logic [63:0] sort_vec(input logic [63:0] v, input bit desc);
        logic [7:0] a [8];
        logic [7:0] t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            spipe[s][0] <= sort_vec(sort_in_w[s], s == 1);
            for (int i = 1; i < LAT; i++) spipe[s][i] <= spipe[s][i-1];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst_n) begin
                cur_blk[s].delete();
                exp_q[s].delete();
                prev_stall[s] = 1'b0;
            end else begin
                if (prev_stall[s])
                    chk($sformatf("stall_hold%0d", s), {out_valid[s], out_data[s]}, {1'b1, prev_data[s]});
                if (out_valid[s] && out_ready[s])
                    chk($sformatf("out_elem%0d", s), {1'b1, out_last[s], out_data[s]},
                        (exp_q[s].size() != 0) ? {1'b1, exp_q[s].pop_front()} : 10'h0);
                if (in_valid[s] && in_ready[s]) begin
                    cur_blk[s].push_back(in_data[s]);
                    if (in_last[s] || cur_blk[s].size() == 8) begin
                        mon_n = cur_blk[s].size();
                        for (int i = 0; i < mon_n; i++) mon_a[i] = cur_blk[s][i];
                        for (int i = 0; i < mon_n; i++)
                            for (int j = 0; j < mon_n - 1 - i; j++)
                                if ((s == 1) ? (mon_a[j] < mon_a[j+1]) : (mon_a[j] > mon_a[j+1])) begin
                                    mon_t = mon_a[j]; mon_a[j] = mon_a[j+1]; mon_a[j+1] = mon_t;
                                end
                        for (int i = 0; i < mon_n; i++) exp_q[s].push_back({i == mon_n - 1, mon_a[i]});
                        cur_blk[s].delete();
                    end
                end
                prev_stall[s] = out_valid[s] && !out_ready[s];
                prev_data[s]  = out_data[s];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one element until accepted; rprob < 0 leaves out_ready untouched
    task automatic push_elem(input int s, input logic [7:0] d, input bit last, input int vprob, input int rprob);
        int  guard = 0;
        bit  acc = 1'b0;
        while (!acc && guard < 300) begin
            in_valid[s] = ($urandom_range(99) < vprob);
            in_data[s]  = d;
            in_last[s]  = last;
            if (rprob >= 0) out_ready[s] = ($urandom_range(99) < rprob);
            acc = in_valid[s] && in_ready[s];
            cyc();
            guard++;
        end
        in_valid[s] = 1'b0;
        in_last[s]  = 1'b0;
        chk($sformatf("accept%0d", s), 64'(acc), 64'd1);
    endtask

    task automatic wait_drain(input int s, input int bound);
        int g = 0;
        out_ready[s] = 1'b1;
        while ((exp_q[s].size() != 0 || busy[s]) && g < bound) begin
            cyc();
            g++;
        end
        chk($sformatf("drain%0d", s), {busy[s], exp_q[s].size() != 0}, 64'd0);
    endtask

    initial begin
        int acc_cnt;
        bit acc;
        int n;
        logic [7:0] bp_vals [24];

        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0; in_last[s] = 1'b0; in_data[s] = 8'h00; out_ready[s] = 1'b0;
            prev_stall[s] = 1'b0; prev_data[s] = 8'h00;
        end
        repeat (3) cyc();

        // Reset state
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_in_ready%0d", s), 64'(in_ready[s]), 64'd0);
            chk($sformatf("rst_out%0d", s), {out_valid[s], out_last[s], out_data[s]}, 64'd0);
            chk($sformatf("rst_busy%0d", s), 64'(busy[s]), 64'd0);
        end
        chk("rst_sort_in0", sort_in_w[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_sort_in1", sort_in_w[1], 64'h0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_in_ready0", 64'(in_ready[0]), 64'd1);
        chk("post_rst_in_ready1", 64'(in_ready[1]), 64'd1);

        // Full ascending block with latency check
        out_ready[0] = 1'b1;
        push_elem(0, 8'd7, 0, 100, -1); push_elem(0, 8'd3, 0, 100, -1);
        push_elem(0, 8'd0, 0, 100, -1); push_elem(0, 8'd5, 0, 100, -1);
        push_elem(0, 8'd1, 0, 100, -1); push_elem(0, 8'd6, 0, 100, -1);
        push_elem(0, 8'd2, 0, 100, -1); push_elem(0, 8'd4, 0, 100, -1);
        chk("launch_sort_in", sort_in_w[0], 64'h0402060105000307);
        for (int k = 1; k <= LAT + 1; k++) begin
            cyc();
            if (k == LAT) chk("lat_not_early", 64'(out_valid[0]), 64'd0);
        end
        chk("lat_valid", 64'(out_valid[0]), 64'd1);
        chk("first_out", {out_last[0], out_data[0]}, 64'h000);
        wait_drain(0, 100);

        // Partial block, pads must not appear
        push_elem(0, 8'd9, 0, 100, -1); push_elem(0, 8'd2, 0, 100, -1); push_elem(0, 8'd5, 1, 100, -1);
        chk("partial_sort_in", sort_in_w[0], 64'hFFFF_FFFF_FF05_0209);
        wait_drain(0, 100);

        // in_last on the eighth element closes exactly one block
        for (int i = 0; i < 8; i++) push_elem(0, 8'($urandom_range(255)), i == 7, 100, -1);
        wait_drain(0, 100);
        repeat (3) cyc();
        chk("no_extra_block", {out_valid[0], busy[0]}, 64'd0);

        // Descending partial block
        out_ready[1] = 1'b1;
        push_elem(1, 8'd1, 0, 100, -1); push_elem(1, 8'd8, 0, 100, -1); push_elem(1, 8'd3, 1, 100, -1);
        chk("desc_sort_in", sort_in_w[1], 64'h0000_0000_0003_0801);
        wait_drain(1, 100);

        // Backpressure with a single buffer block
        for (int i = 0; i < 24; i++) bp_vals[i] = 8'($urandom_range(255));
        out_ready[1] = 1'b0;
        acc_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            in_valid[1] = (acc_cnt < 24);
            in_data[1]  = (acc_cnt < 24) ? bp_vals[acc_cnt] : 8'h00;
            in_last[1]  = 1'b0;
            acc = in_valid[1] && in_ready[1];
            cyc();
            if (acc) acc_cnt++;
        end
        chk("bp_accepted", 64'(acc_cnt), 64'd16);
        chk("bp_in_ready", 64'(in_ready[1]), 64'd0);
        chk("bp_busy_valid", {busy[1], out_valid[1]}, 64'h3);
        out_ready[1] = 1'b1;
        for (int i = acc_cnt; i < 24; i++) push_elem(1, bp_vals[i], 0, 100, -1);
        wait_drain(1, 200);

        // Random traffic on both configurations
        for (int b = 0; b < 1000; b++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++)
                push_elem(0, 8'($urandom_range(255)), (i == n - 1) && (n < 8 || $urandom_range(1) == 1), 70, 70);
        end
        wait_drain(0, 500);
        for (int b = 0; b < 200; b++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++)
                push_elem(1, 8'($urandom_range(255)), (i == n - 1) && (n < 8 || $urandom_range(1) == 1), 80, 60);
        end
        wait_drain(1, 500);

        // Reset mid-drain with a block still in flight
        out_ready[0] = 1'b0;
        for (int i = 0; i < 16; i++) push_elem(0, 8'($urandom_range(255)), 0, 100, -1);
        chk("mid_valid", 64'(out_valid[0]), 64'd1);
        out_ready[0] = 1'b1;
        cyc(); cyc();
        out_ready[0] = 1'b0;
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("mid_rst_busy", 64'(busy[0]), 64'd0);
        rst_n = 1'b1;
        repeat (10) cyc();
        chk("stale_ignored", {out_valid[0], busy[0]}, 64'd0);
        out_ready[0] = 1'b1;
        for (int i = 0; i < 5; i++) push_elem(0, 8'($urandom_range(255)), i == 4, 100, -1);
        wait_drain(0, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
